// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard driving pipeline stalls, flushes and freeze.
// Outputs are combinational from ID inputs and state; state updates on non-frozen cycles.
module hazard_scoreboard #(
    parameter int NREGS        = 32,
    parameter int REGW         = 5,
    parameter int FWD_EN       = 1,
    parameter int LOAD_STALL   = 1,
    parameter int ALU_STALL    = 0,
    parameter int NOFWD_STALL  = 2,
    parameter int CNTW         = 3,
    parameter int CANCEL_DEPTH = 1,
    parameter int PERFW        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwr,
    input  logic [REGW-1:0]  id_dest,
    input  logic             id_is_load,
    input  logic             redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             enable_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             freeze,
    output logic [1:0]       hazard,
    output logic [PERFW-1:0] stall_count
);

    localparam logic [CNTW-1:0] S_LOAD = CNTW'((FWD_EN != 0) ? LOAD_STALL : NOFWD_STALL);
    localparam logic [CNTW-1:0] S_ALU  = CNTW'((FWD_EN != 0) ? ALU_STALL  : NOFWD_STALL);

    logic [CNTW-1:0] cnt     [NREGS];
    logic [CNTW-1:0] cnt_nxt [NREGS];
    logic            hv      [CANCEL_DEPTH];
    logic [REGW-1:0] hdest   [CANCEL_DEPTH];
    logic [CNTW-1:0] hsaved  [CANCEL_DEPTH];

    logic dstall, stall_eff, issue, wr_new;
    int   rb;

    assign dstall = id_valid &&
                    ((id_uses_rs && id_rs != '0 && cnt[id_rs] != '0) ||
                     (id_uses_rt && id_rt != '0 && cnt[id_rt] != '0));
    assign stall_eff = dstall && !redirect && !mem_busy;
    assign issue     = id_valid && !mem_busy && !redirect && !dstall;
    assign wr_new    = issue && id_regwr && id_dest != '0;

    always_comb begin
        pc_stall  = 1'b0;
        enable_id = 1'b1;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        freeze    = 1'b0;
        hazard    = 2'b00;
        if (mem_busy) begin
            freeze    = 1'b1;
            pc_stall  = 1'b1;
            enable_id = 1'b0;
            hazard    = 2'b11;
        end else if (redirect) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            hazard    = 2'b01;
        end else if (dstall) begin
            pc_stall  = 1'b1;
            enable_id = 1'b0;
            flush_ex  = 1'b1;
            hazard    = 2'b10;
        end
    end

    always_comb begin
        rb = 0;
        for (int r = 0; r < NREGS; r++)
            cnt_nxt[r] = (r != 0 && cnt[r] != '0) ? cnt[r] - CNTW'(1) : cnt[r];
        if (wr_new)
            cnt_nxt[id_dest] = id_is_load ? S_LOAD : S_ALU;
        // Youngest first so the oldest squashed writer's snapshot is the one that sticks.
        if (redirect) begin
            for (int i = 0; i < CANCEL_DEPTH; i++) begin
                if (hv[i] && hdest[i] != '0) begin
                    rb = int'(hsaved[i]) - i - 2;
                    cnt_nxt[hdest[i]] = (rb > 0) ? CNTW'(rb) : '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= '0;
            for (int i = 0; i < CANCEL_DEPTH; i++) begin
                hv[i]     <= 1'b0;
                hdest[i]  <= '0;
                hsaved[i] <= '0;
            end
            stall_count <= '0;
        end else if (!mem_busy) begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= cnt_nxt[r];
            for (int i = CANCEL_DEPTH - 1; i > 0; i--) begin
                hv[i]     <= hv[i-1] && !redirect;
                hdest[i]  <= hdest[i-1];
                hsaved[i] <= hsaved[i-1];
            end
            hv[0]     <= wr_new;
            hdest[0]  <= id_dest;
            hsaved[0] <= cnt[id_dest];
            if (stall_eff && stall_count != '1)
                stall_count <= stall_count + PERFW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding and no-forwarding instances side by side,
// expected output vectors queued when a cycle's stimulus is driven and checked mid-cycle.
module tb_hazard_scoreboard;

    localparam logic [7:0] IDLE = 8'b0100_0000;
    localparam logic [7:0] DST  = 8'b1001_0010;
    localparam logic [7:0] RDR  = 8'b0111_1001;
    localparam logic [7:0] FRZ  = 8'b1000_0111;
    localparam logic [7:0] SKIP = 8'hFF;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       id_valid = 1'b0, id_uses_rs = 1'b1, id_uses_rt = 1'b1;
    logic       id_regwr = 1'b0, id_is_load = 1'b0, redirect = 1'b0, mem_busy = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;

    logic        pc_stall, enable_id, flush_id, flush_ex, flush_mem, freeze;
    logic [1:0]  hazard;
    logic [31:0] stall_count;
    logic        n_pc_stall, n_enable_id, n_flush_id, n_flush_ex, n_flush_mem, n_freeze;
    logic [1:0]  n_hazard;
    logic [31:0] n_stall_count;

    logic [7:0] outv, outn;
    logic [7:0] qe[$], qn[$];
    int n_chk = 0, n_fail = 0;

    assign outv = {pc_stall, enable_id, flush_id, flush_ex, flush_mem, freeze, hazard};
    assign outn = {n_pc_stall, n_enable_id, n_flush_id, n_flush_ex, n_flush_mem, n_freeze, n_hazard};

    always #5 CLK = ~CLK;

    hazard_scoreboard dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr),
        .id_dest(id_dest), .id_is_load(id_is_load), .redirect(redirect), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .enable_id(enable_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .flush_mem(flush_mem), .freeze(freeze), .hazard(hazard), .stall_count(stall_count)
    );

    hazard_scoreboard #(.FWD_EN(0)) dut_nf (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr),
        .id_dest(id_dest), .id_is_load(id_is_load), .redirect(redirect), .mem_busy(mem_busy),
        .pc_stall(n_pc_stall), .enable_id(n_enable_id), .flush_id(n_flush_id),
        .flush_ex(n_flush_ex), .flush_mem(n_flush_mem), .freeze(n_freeze),
        .hazard(n_hazard), .stall_count(n_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input string tag, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic wr,
                        input logic [4:0] dst, input logic ld, input logic rd,
                        input logic mb, input logic [7:0] e, input logic [7:0] enf);
        logic [7:0] ee, en;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_regwr = wr;
        id_dest = dst; id_is_load = ld; redirect = rd; mem_busy = mb;
        qe.push_back(e);
        qn.push_back(enf);
        @(negedge CLK);
        ee = qe.pop_front();
        en = qn.pop_front();
        if (ee != SKIP) chk(tag, {24'd0, outv}, {24'd0, ee});
        if (en != SKIP) chk({tag, "_nf"}, {24'd0, outn}, {24'd0, en});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #3;
        chk("reset_out", {24'd0, outv}, {24'd0, IDLE});
        chk("reset_sc", stall_count, 32'd0);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK) #1;

        // Forwarding instance: load-use, ALU chain, redirect, freeze, r0
        step("lw_r2",      1, 1, 0, 1, 1, 2, 1, 0, 0, IDLE, SKIP);
        step("ld_use",     1, 2, 4, 1, 1, 3, 0, 0, 0, DST,  SKIP);
        chk("sc_after_stall", stall_count, 32'd1);
        step("ld_use_go",  1, 2, 4, 1, 1, 3, 0, 0, 0, IDLE, SKIP);
        step("alu_fwd",    1, 3, 3, 1, 1, 6, 0, 0, 0, IDLE, SKIP);
        step("lw_r7",      1, 1, 0, 1, 1, 7, 1, 0, 0, IDLE, SKIP);
        step("redirect",   1, 7, 0, 1, 1, 8, 0, 1, 0, RDR,  SKIP);
        chk("sc_redirect", stall_count, 32'd1);
        step("use_r7",     1, 7, 0, 1, 1, 8, 0, 0, 0, IDLE, SKIP);
        step("lw_r2b",     1, 1, 0, 1, 1, 2, 1, 0, 0, IDLE, SKIP);
        for (int i = 0; i < 3; i++)
            step("freeze", 1, 2, 4, 1, 1, 3, 0, 0, 1, FRZ,  SKIP);
        chk("sc_freeze", stall_count, 32'd1);
        step("resume",     1, 2, 4, 1, 1, 3, 0, 0, 0, DST,  SKIP);
        chk("sc_resume", stall_count, 32'd2);
        step("resume_go",  1, 2, 4, 1, 1, 3, 0, 0, 0, IDLE, SKIP);
        step("frz_redir",  0, 0, 0, 1, 0, 0, 0, 1, 1, FRZ,  SKIP);
        step("redir_rel",  0, 0, 0, 1, 0, 0, 0, 1, 0, RDR,  SKIP);
        step("lw_r0",      1, 1, 0, 1, 1, 0, 1, 0, 0, IDLE, SKIP);
        step("use_r0",     1, 0, 0, 1, 1, 4, 0, 0, 0, IDLE, SKIP);
        step("lw_r2c",     1, 1, 0, 1, 1, 2, 1, 0, 0, IDLE, SKIP);
        step("rt_unused",  1, 1, 2, 0, 1, 4, 0, 0, 0, IDLE, SKIP);

        @(negedge CLK) RST = 1'b1;
        #1 chk("rst_pulse_sc", stall_count, 32'd0);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK) #1;

        // Both instances: no-forwarding stalls, rollback, reset mid-stall
        step("add_r5",     1, 1, 0, 1, 1, 5, 0, 0, 0, IDLE, IDLE);
        step("sub_r5_a",   1, 5, 0, 1, 1, 6, 0, 0, 0, IDLE, DST);
        step("sub_r5_b",   1, 5, 0, 1, 1, 6, 0, 0, 0, IDLE, DST);
        step("sub_r5_go",  1, 5, 0, 1, 1, 6, 0, 0, 0, IDLE, IDLE);
        chk("nf_sc_2", n_stall_count, 32'd2);
        step("add_r7",     1, 1, 0, 1, 1, 7, 0, 0, 0, IDLE, IDLE);
        step("redir_rb",   1, 1, 0, 1, 0, 0, 0, 1, 0, RDR,  RDR);
        step("use_r7_rb",  1, 7, 0, 1, 0, 0, 0, 0, 0, IDLE, IDLE);
        step("add_r9",     1, 1, 0, 1, 1, 9, 0, 0, 0, IDLE, IDLE);
        step("use_r9",     1, 9, 0, 1, 0, 0, 0, 0, 0, IDLE, DST);
        chk("nf_sc_3", n_stall_count, 32'd3);
        #1 chk("pre_rst_stall", {24'd0, outn}, {24'd0, DST});
        RST = 1'b1;
        #1 chk("rst_mid_out", {24'd0, outn}, {24'd0, IDLE});
        chk("rst_mid_sc", n_stall_count, 32'd0);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK) #1;
        step("use_r9_rst", 1, 9, 0, 1, 0, 0, 0, 0, 0, IDLE, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
